timestamp_clk_gen: RTL and testbench

Parametrised timestamp clock generator for the Astropix readout firmware. It divides `timestamp_int_clk` by a programmable ratio and fans the result out to `NCH` chip timestamp inputs, each with a glitch-free enable. It also keeps a shadow timestamp counter with overflow tracking and a synchronous restart, so that FPGA-side data can be time-aligned with the chip timestamps. It generalises the fixed divide-by-2 timestamp output to multi-chip (telescope) setups.

---
 rtl/timestamp_clk_gen.sv | 110 +++++++++++
 tb/tb_timestamp_clk_gen.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/timestamp_clk_gen.sv
// Programmable timestamp clock divider with per-channel glitch-free gating,
// a shadow timestamp counter with overflow tracking, and a synchronous restart.
module timestamp_clk_gen #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned DIV_W = 8,
    parameter int unsigned TS_W  = 16,
    parameter int unsigned OVF_W = 16
) (
    input  logic             timestamp_int_clk,
    input  logic             cpu_resetn,
    input  logic             run,
    input  logic [DIV_W-1:0] div_ratio,
    input  logic [NCH-1:0]   ch_enable,
    input  logic             sync_req,
    output logic [NCH-1:0]   ts_clk_out,
    output logic [TS_W-1:0]  ts_count,
    output logic [OVF_W-1:0] ovf_count,
    output logic             ovf_pulse,
    output logic             sync_ack,
    output logic             div_clk
);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] r_q;

    logic [DIV_W-1:0] div_cnt_d;
    logic [DIV_W-1:0] r_d;
    logic             div_clk_d;
    logic [NCH-1:0]   ts_clk_d;
    logic [TS_W-1:0]  ts_count_d;
    logic [OVF_W-1:0] ovf_count_d;
    logic             ovf_pulse_d;
    logic             sync_ack_d;

    logic [DIV_W-1:0] ratio_sat;
    logic [DIV_W-1:0] r_eff;
    logic             half_end;
    logic             ts_wrap;

    // r_q is 0 only straight after reset; the live ratio stands in until the first load
    assign ratio_sat = (div_ratio == '0) ? DIV_W'(1) : div_ratio;
    assign r_eff     = (r_q == '0) ? ratio_sat : r_q;
    assign half_end  = (div_cnt >= (r_eff - DIV_W'(1)));
    assign ts_wrap   = &ts_count;

    // Next-state: restart beats counting; ratio only reloads on a phase boundary
    always_comb begin
        div_cnt_d   = div_cnt;
        r_d         = r_eff;
        div_clk_d   = div_clk;
        ts_clk_d    = ts_clk_out;
        ts_count_d  = ts_count;
        ovf_count_d = ovf_count;
        ovf_pulse_d = 1'b0;
        sync_ack_d  = 1'b0;

        if (sync_req) begin
            div_cnt_d   = '0;
            r_d         = ratio_sat;
            div_clk_d   = 1'b0;
            ts_clk_d    = '0;
            ts_count_d  = '0;
            ovf_count_d = '0;
            sync_ack_d  = 1'b1;
        end else if (run) begin
            if (half_end) begin
                div_cnt_d = '0;
                div_clk_d = ~div_clk;
                r_d       = ratio_sat;
                if (!div_clk) begin
                    // Enables are sampled only at the rising edge, so pulses are whole or absent
                    ts_clk_d   = ch_enable;
                    ts_count_d = ts_count + TS_W'(1);
                    if (ts_wrap) begin
                        ovf_pulse_d = 1'b1;
                        ovf_count_d = ovf_count + OVF_W'(1);
                    end
                end else begin
                    ts_clk_d = '0;
                end
            end else begin
                div_cnt_d = div_cnt + DIV_W'(1);
            end
        end
    end

    // State and output registers
    always_ff @(posedge timestamp_int_clk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            div_cnt    <= '0;
            r_q        <= '0;
            div_clk    <= 1'b0;
            ts_clk_out <= '0;
            ts_count   <= '0;
            ovf_count  <= '0;
            ovf_pulse  <= 1'b0;
            sync_ack   <= 1'b0;
        end else begin
            div_cnt    <= div_cnt_d;
            r_q        <= r_d;
            div_clk    <= div_clk_d;
            ts_clk_out <= ts_clk_d;
            ts_count   <= ts_count_d;
            ovf_count  <= ovf_count_d;
            ovf_pulse  <= ovf_pulse_d;
            sync_ack   <= sync_ack_d;
        end
    end

endmodule

// File: tb/tb_timestamp_clk_gen.sv
// Directed bench for timestamp_clk_gen; expectations are queued before each
// edge and popped against the outputs on the following falling edge.
module tb_timestamp_clk_gen;

    localparam int unsigned NCH   = 4;
    localparam int unsigned DIV_W = 8;
    localparam int unsigned TS_W  = 4;
    localparam int unsigned OVF_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             run;
    logic [DIV_W-1:0] div_ratio;
    logic [NCH-1:0]   ch_enable;
    logic             sync_req;
    logic [NCH-1:0]   ts_clk_out;
    logic [TS_W-1:0]  ts_count;
    logic [OVF_W-1:0] ovf_count;
    logic             ovf_pulse;
    logic             sync_ack;
    logic             div_clk;

    timestamp_clk_gen #(
        .NCH  (NCH),
        .DIV_W(DIV_W),
        .TS_W (TS_W),
        .OVF_W(OVF_W)
    ) dut (
        .timestamp_int_clk(clk),
        .cpu_resetn       (rst_n),
        .run              (run),
        .div_ratio        (div_ratio),
        .ch_enable        (ch_enable),
        .sync_req         (sync_req),
        .ts_clk_out       (ts_clk_out),
        .ts_count         (ts_count),
        .ovf_count        (ovf_count),
        .ovf_pulse        (ovf_pulse),
        .sync_ack         (sync_ack),
        .div_clk          (div_clk)
    );

    always #5 clk = ~clk;

    string       q_tag[$];
    logic [31:0] q_exp[$];
    int          errors = 0;
    int          checks = 0;

    task automatic push(input string tag, input logic [31:0] v);
        q_tag.push_back(tag);
        q_exp.push_back(v);
    endtask

    task automatic pop(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        checks++;
        if (q_exp.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %0h with no expected entry", obs);
        end else begin
            t = q_tag.pop_front();
            e = q_exp.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed %0h expected %0h", t, obs, e);
            end
        end
    endtask

    task automatic exp_all(input string tag, input int tsc, input int dc, input int cnt,
                           input int ovc, input int ovp, input int ack);
        push({tag, "/ts_clk_out"}, 32'(tsc));
        push({tag, "/div_clk"},    32'(dc));
        push({tag, "/ts_count"},   32'(cnt));
        push({tag, "/ovf_count"},  32'(ovc));
        push({tag, "/ovf_pulse"},  32'(ovp));
        push({tag, "/sync_ack"},   32'(ack));
    endtask

    task automatic obs_all();
        pop(32'(ts_clk_out));
        pop(32'(div_clk));
        pop(32'(ts_count));
        pop(32'(ovf_count));
        pop(32'(ovf_pulse));
        pop(32'(sync_ack));
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_sync();
        sync_req = 1'b1;
        tick(1);
        sync_req = 1'b0;
    endtask

    // pat is read left to right: its MSB (of n bits) is the first edge
    task automatic chk_dclk_seq(input string tag, input int n, input logic [15:0] pat);
        for (int i = 0; i < n; i++) begin
            push(tag, 32'(pat[n-1-i]));
            tick(1);
            pop(32'(div_clk));
        end
    endtask

    initial begin
        logic en2;
        logic en_rise;
        logic [15:0] pat;

        rst_n     = 1'b0;
        run       = 1'b0;
        div_ratio = DIV_W'(1);
        ch_enable = '0;
        sync_req  = 1'b0;
        tick(2);
        exp_all("reset", 0, 0, 0, 0, 0, 0);
        obs_all();

        // Divide-by-2 straight out of reset
        rst_n     = 1'b1;
        run       = 1'b1;
        ch_enable = 4'hF;
        for (int i = 1; i <= 20; i++) begin
            exp_all("div2", (i % 2) ? 15 : 0, i % 2, (i + 1) / 2, 0, 0, 0);
            tick(1);
            obs_all();
        end

        // Restart with R=2: ack at k, first rise at k+2
        div_ratio = DIV_W'(2);
        sync_req  = 1'b1;
        exp_all("sync_k", 0, 0, 0, 0, 0, 1);
        tick(1);
        obs_all();
        sync_req = 1'b0;
        exp_all("sync_k1", 0, 0, 0, 0, 0, 0);
        tick(1);
        obs_all();
        exp_all("sync_k2", 15, 1, 1, 0, 0, 0);
        tick(1);
        obs_all();

        // Divide by 3, then change to 5 during the high phase
        div_ratio = DIV_W'(3);
        do_sync();
        pat = 16'b0000_0011_1000_1110;
        chk_dclk_seq("div3", 12, pat);
        do_sync();
        pat = 16'b0000_0000_0000_0011;
        chk_dclk_seq("div3_pre", 4, pat);
        div_ratio = DIV_W'(5);
        pat = 16'b0000_1000_0011_1110;
        chk_dclk_seq("div5_change", 12, pat);

        // ch2 enable toggled at every offset of an 8-cycle period
        div_ratio = DIV_W'(4);
        ch_enable = 4'hF;
        do_sync();
        en2     = 1'b1;
        en_rise = 1'b1;
        for (int o = 0; o < 8; o++) begin
            for (int j = 0; j < 8; j++) begin
                if (j == o) en2 = ~en2;
                ch_enable = {1'b1, en2, 2'b11};
                if (j == 3) en_rise = en2;
                exp_all("gate", (j >= 3 && j <= 6) ? int'({1'b1, en_rise, 2'b11}) : 0,
                        (j >= 3 && j <= 6) ? 1 : 0, (j >= 3) ? o + 1 : o, 0, 0, 0);
                tick(1);
                obs_all();
            end
        end

        // Wrap of the 4-bit shadow counter over 32 rises
        div_ratio = DIV_W'(1);
        ch_enable = 4'hF;
        do_sync();
        for (int n = 1; n <= 32; n++) begin
            exp_all("wrap_rise", 15, 1, n % 16, n / 16, (n % 16 == 0) ? 1 : 0, 0);
            tick(1);
            obs_all();
            exp_all("wrap_fall", 0, 0, n % 16, n / 16, 0, 0);
            tick(1);
            obs_all();
        end
        tick(30);
        // Next edge would wrap; the restart must win
        sync_req = 1'b1;
        exp_all("sync_on_wrap", 0, 0, 0, 0, 0, 1);
        tick(1);
        obs_all();
        sync_req = 1'b0;

        // Freeze in the high phase, then resume
        div_ratio = DIV_W'(2);
        do_sync();
        tick(3);
        run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            exp_all("freeze", 15, 1, 1, 0, 0, 0);
            tick(1);
            obs_all();
        end
        run = 1'b1;
        exp_all("resume1", 0, 0, 1, 0, 0, 0);
        tick(1);
        obs_all();
        exp_all("resume2", 0, 0, 1, 0, 0, 0);
        tick(1);
        obs_all();
        exp_all("resume3", 15, 1, 2, 0, 0, 0);
        tick(1);
        obs_all();

        // Asynchronous reset in the middle of a high phase
        tick(1);
        #3;
        rst_n = 1'b0;
        #1;
        exp_all("async_reset", 0, 0, 0, 0, 0, 0);
        obs_all();
        tick(1);
        rst_n = 1'b1;
        tick(1);
        exp_all("post_reset", 15, 1, 1, 0, 0, 0);
        tick(1);
        obs_all();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
